// File: rtl/aw_ch_arbiter.sv
// AXI write-address stage: round-robin between M1/M2, decodes the target slave,
// forwards one registered AW beat and holds the channel until W and B complete.
module aw_ch_arbiter #(
    parameter int IDW   = 4,
    parameter int ADDRW = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDW-1:0]   awid_m1_i,
    input  logic [ADDRW-1:0] awaddr_m1_i,
    input  logic [3:0]       awlen_m1_i,
    input  logic [2:0]       awsize_m1_i,
    input  logic [1:0]       awburst_m1_i,
    input  logic             awvalid_m1_i,
    output logic             awready_m1_o,
    input  logic [IDW-1:0]   awid_m2_i,
    input  logic [ADDRW-1:0] awaddr_m2_i,
    input  logic [3:0]       awlen_m2_i,
    input  logic [2:0]       awsize_m2_i,
    input  logic [1:0]       awburst_m2_i,
    input  logic             awvalid_m2_i,
    output logic             awready_m2_o,
    output logic [IDW+3:0]   awid_s_o,
    output logic [ADDRW-1:0] awaddr_s_o,
    output logic [3:0]       awlen_s_o,
    output logic [2:0]       awsize_s_o,
    output logic [1:0]       awburst_s_o,
    output logic [7:0]       awvalid_s_o,
    input  logic [7:0]       awready_s_i,
    input  logic             w_last_done_i,
    input  logic             b_done_i,
    output logic [1:0]       grant_o,
    output logic             busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t           r_state;
    logic             r_ptr_m2;
    logic [2:0]       r_slv;
    logic             r_w_seen;
    logic [1:0]       r_grant;
    logic [IDW+3:0]   r_id;
    logic [ADDRW-1:0] r_addr;
    logic [3:0]       r_len;
    logic [2:0]       r_size;
    logic [1:0]       r_burst;

    logic             w_idle;
    logic             w_req;
    logic             w_sel_m2;
    logic             w_accept;
    logic [ADDRW-1:0] w_addr;

    // Index 7 is the default slave; everything unmapped lands there.
    function automatic logic [2:0] f_decode(input logic [15:0] hi);
        logic [2:0] slv;
        slv = 3'd7;
        if (hi == 16'h0000)              slv = 3'd0;
        else if (hi == 16'h0001)         slv = 3'd1;
        else if (hi == 16'h0002)         slv = 3'd2;
        else if (hi == 16'h1000)         slv = 3'd3;
        else if (hi == 16'h1001)         slv = 3'd4;
        else if (hi[15:5] == 11'h100)    slv = 3'd5;
        else if (hi == 16'h3000)         slv = 3'd6;
        return slv;
    endfunction

    assign w_idle   = (r_state == S_IDLE);
    assign w_req    = awvalid_m1_i | awvalid_m2_i;
    assign w_sel_m2 = awvalid_m2_i & (~awvalid_m1_i | r_ptr_m2);
    assign w_addr   = w_sel_m2 ? awaddr_m2_i : awaddr_m1_i;
    assign w_accept = awready_s_i[r_slv];

    // rst gates the ready so a held request is not acknowledged during reset.
    assign awready_m1_o = rst & w_idle & awvalid_m1_i & ~w_sel_m2;
    assign awready_m2_o = rst & w_idle & w_sel_m2;

    always_comb begin
        awvalid_s_o = '0;
        if (r_state == S_ADDR)
            awvalid_s_o[r_slv] = 1'b1;
    end

    assign awid_s_o    = r_id;
    assign awaddr_s_o  = r_addr;
    assign awlen_s_o   = r_len;
    assign awsize_s_o  = r_size;
    assign awburst_s_o = r_burst;
    assign grant_o     = r_grant;
    assign busy_o      = ~w_idle;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_ptr_m2 <= 1'b0;
            r_slv    <= '0;
            r_w_seen <= 1'b0;
            r_grant  <= '0;
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_id     <= w_sel_m2 ? {4'h2, awid_m2_i} : {4'h1, awid_m1_i};
                        r_addr   <= w_addr;
                        r_len    <= w_sel_m2 ? awlen_m2_i   : awlen_m1_i;
                        r_size   <= w_sel_m2 ? awsize_m2_i  : awsize_m1_i;
                        r_burst  <= w_sel_m2 ? awburst_m2_i : awburst_m1_i;
                        r_slv    <= f_decode(w_addr[31:16]);
                        r_grant  <= w_sel_m2 ? 2'b10 : 2'b01;
                        r_ptr_m2 <= ~w_sel_m2;
                        r_state  <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    // The W mux routes on awvalid, so the burst may finish before AW is accepted.
                    if (w_last_done_i)
                        r_w_seen <= 1'b1;
                    if (w_accept)
                        r_state <= (r_w_seen | w_last_done_i) ? S_RESP : S_DATA;
                end
                S_DATA: begin
                    if (w_last_done_i)
                        r_state <= S_RESP;
                end
                S_RESP: begin
                    if (b_done_i) begin
                        r_state  <= S_IDLE;
                        r_grant  <= '0;
                        r_w_seen <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/aw_ch_arbiter.md
Name: aw_ch_arbiter

Overview:
- Write-address (AW) channel stage of the AXI interconnect. It sits directly upstream of the W-channel mux and feeds it the per-slave awvalid vector it routes on.
- Arbitrates round-robin between write masters M1 and M2 (M0 is read-only) and decodes AWADDR to one of S0–S6 or the default slave.
- Forwards the registered AW beat with an extended ID, then locks the channel until the W burst and the B response complete. One outstanding write.

Parameters:
- IDW, 4, master-side AWID width; slave-side ID is IDW+4 = {master tag[3:0], AWID}.
- ADDRW, 32, address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- awid_m1_i  in  IDW  M1 ID
- awaddr_m1_i  in  ADDRW  M1 address
- awlen_m1_i  in  4  M1 burst length
- awsize_m1_i  in  3  M1 burst size
- awburst_m1_i  in  2  M1 burst type
- awvalid_m1_i  in  1  M1 valid
- awready_m1_o  out  1  M1 ready
- awid_m2_i / awaddr_m2_i / awlen_m2_i / awsize_m2_i / awburst_m2_i / awvalid_m2_i  in  as M1  M2 request
- awready_m2_o  out  1  M2 ready
- awid_s_o  out  IDW+4  shared slave ID; tag 4'h1 = M1, 4'h2 = M2
- awaddr_s_o  out  ADDRW  shared slave address
- awlen_s_o  out  4  shared slave burst length
- awsize_s_o  out  3  shared slave burst size
- awburst_s_o  out  2  shared slave burst type
- awvalid_s_o  out  8  one-hot slave valid; bit7 = default slave, bits6..0 = S6..S0
- awready_s_i  in  8  per-slave ready
- w_last_done_i  in  1  W last-beat handshake on the granted path (wvalid & wready & wlast)
- b_done_i  in  1  B handshake returned to the granted master (bvalid & bready)
- grant_o  out  2  one-hot owning master {M2, M1}; 0 when idle
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, all awready_m*_o=0, awvalid_s_o=0, grant_o=0, busy_o=0, registered AW fields=0, w_seen=0, priority pointer=M1.
- FSM IDLE -> ADDR -> DATA -> RESP -> IDLE.
- IDLE:
  - If any awvalid_m is high, select a master. Only one valid: that master. Both valid: the priority-pointer master.
  - In the same cycle, awready for the selected master = 1 (combinational). The other master's awready = 0.
  - Capture id/addr/len/size/burst and the decoded slave index into registers. Set grant_o.
  - Toggle the pointer to the non-selected master. Go to ADDR.
  - If no master is valid, both awready = 0.
- Decode on addr[31:16]:
  - 0x0000 -> S0; 0x0001 -> S1; 0x0002 -> S2
  - 0x1000 -> S3; 0x1001 -> S4
  - 0x2000–0x201F -> S5
  - 0x3000 -> S6
  - all other values -> default slave (bit7)
- ADDR:
  - awvalid_s_o = one-hot of the registered slave. Shared fields are driven from the registers and held stable.
  - Stay until awready_s_i[sel]=1. Then awvalid drops the next cycle.
  - If w_last_done_i=1 during ADDR, set w_seen (W can complete early because the W mux routes on awvalid).
  - On accept, go to RESP if (w_seen | w_last_done_i), else go to DATA.
- DATA: awvalid_s_o=0. Wait for w_last_done_i, then go to RESP.
- RESP: wait for b_done_i, then go to IDLE with grant_o=0 and w_seen=0. A new grant is possible only from the following cycle.
- Latency: master handshake in cycle N -> slave awvalid in cycle N+1 at the earliest. Minimum write occupancy is 3 cycles.
- awready_m*_o is 0 in every state except IDLE. Requests arriving while busy wait; no drop, no reordering.
- b_done_i or w_last_done_i asserted in IDLE or in an unexpected state is ignored. No state change.
- Reset mid-burst returns to IDLE immediately and clears awvalid_s_o asynchronously.
- Only fields are registered: awvalid_s_o is a function of state and the registered index only.

Test Plan:
- M1 alone, addr 0x0001_0040, len 3, id 5 -> awready_m1 pulse, next cycle awvalid_s_o=8'h02, awid_s_o=8'h15. Slave ready after 2 cycles -> awvalid drops. w_last_done then b_done -> IDLE, grant_o=0.
- M1 and M2 valid together from reset, three times back-to-back -> grants M1, M2, M1. The loser's awready stays 0 until the winner's b_done.
- addr 0x5555_0000 from M2 -> awvalid_s_o=8'h80 (default slave), awid_s_o tag 4'h2. addr 0x201F_FFFC -> 8'h20. addr 0x2020_0000 -> 8'h80.
- w_last_done_i asserted while in ADDR with awready_s low -> on slave accept go straight to RESP. b_done releases with no DATA wait.
- Spurious b_done_i and w_last_done_i in IDLE -> no state change. Slave awready held low for 10 cycles -> awvalid and fields remain stable.
- rst dropped in DATA with grant_o=2'b10 -> outputs 0 immediately. After release, a pending M1 request is granted (pointer reset to M1).
